// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small dual-port-fed FIFO.
// Two CPU ports may push bytes in the same cycle; status is readable on either port.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned TX_DATA_ADDR   = 65531,
    parameter int unsigned TX_STATUS_ADDR = 65532,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_a,
    input  logic [15:0] address_b,
    input  logic [15:0] write_data_a,
    input  logic [15:0] write_data_b,
    input  logic        write_enable_a,
    input  logic        write_enable_b,
    output logic        tx,
    output logic [15:0] read_data_a,
    output logic [15:0] read_data_b,
    output logic        read_hit_a,
    output logic        read_hit_b
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [15:0]       DATA_ADDR   = 16'(TX_DATA_ADDR);
    localparam logic [15:0]       STATUS_ADDR = 16'(TX_STATUS_ADDR);
    localparam logic [BAUD_W-1:0] BAUD_MAX    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [2:0]          bit_q;
    logic [7:0]          shift_q;
    logic                tx_q;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;

    logic                wr_a;
    logic                wr_b;
    logic                clr_ovf;
    logic                bit_end;
    logic                fifo_empty;
    logic                fifo_full;
    logic                busy;
    logic                pop;
    logic [CNT_W-1:0]    free_slots;
    logic                acc_a;
    logic                acc_b;
    logic                drop;
    logic                overflow_d;
    logic [CNT_W-1:0]    count_d;
    logic [PTR_W-1:0]    wr_ptr_b;
    logic [7:0]          head;
    logic [15:0]         status;
    logic                unused_wd;

    assign unused_wd = ^{write_data_a[15:8], write_data_b[15:8]};
    assign tx        = tx_q;

    // Push/pop arbitration; free space counts the slot released by a same-cycle pop.
    always_comb begin
        wr_a       = write_enable_a && (address_a == DATA_ADDR);
        wr_b       = write_enable_b && (address_b == DATA_ADDR);
        clr_ovf    = (write_enable_a && (address_a == STATUS_ADDR))
                  || (write_enable_b && (address_b == STATUS_ADDR));
        bit_end    = (baud_q == BAUD_MAX);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        busy       = (state_q != ST_IDLE) || !fifo_empty;
        pop        = !fifo_empty
                  && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
        free_slots = CNT_FULL - count_q + CNT_W'(pop);
        acc_a      = wr_a && (free_slots != '0);
        acc_b      = wr_b && (acc_a ? (free_slots >= CNT_W'(2)) : (free_slots != '0));
        drop       = (wr_a && !acc_a) || (wr_b && !acc_b);
        overflow_d = drop || (overflow_q && !clr_ovf);
        count_d    = count_q + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(pop);
        wr_ptr_b   = wr_ptr_q + PTR_W'(acc_a);
        head       = mem_q[rd_ptr_q];
        status     = {12'd0, overflow_q, fifo_empty, fifo_full, busy};
    end

    always_comb begin
        read_hit_a  = (address_a == STATUS_ADDR);
        read_hit_b  = (address_b == STATUS_ADDR);
        read_data_a = read_hit_a ? status : 16'd0;
        read_data_b = read_hit_b ? status : 16'd0;
    end

    // FIFO storage, pointers and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (acc_a) mem_q[wr_ptr_q] <= write_data_a[7:0];
            if (acc_b) mem_q[wr_ptr_b] <= write_data_b[7:0];
            wr_ptr_q   <= wr_ptr_b + PTR_W'(acc_b);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Serial framer: start, 8 data bits LSB first, stop; back-to-back from STOP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    tx_q   <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: vector table for MMIO behaviour plus
// hand-written frame, back-to-back, pop-while-full and reset sequences.
module tb_mmio_uart_tx;

    localparam int CPB = 4;
    localparam logic [15:0] DATA   = 16'hFFFB;
    localparam logic [15:0] STATUS = 16'hFFFC;
    localparam logic [15:0] OTHER  = 16'h1234;

    logic        clock;
    logic        reset;
    logic [15:0] address_a, address_b;
    logic [15:0] write_data_a, write_data_b;
    logic        write_enable_a, write_enable_b;
    logic        tx;
    logic [15:0] read_data_a, read_data_b;
    logic        read_hit_a, read_hit_b;

    int n_assert = 0;
    int n_fail   = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT  (CPB),
        .TX_DATA_ADDR  (65531),
        .TX_STATUS_ADDR(65532),
        .FIFO_DEPTH    (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address_a     (address_a),
        .address_b     (address_b),
        .write_data_a  (write_data_a),
        .write_data_b  (write_data_b),
        .write_enable_a(write_enable_a),
        .write_enable_b(write_enable_b),
        .tx            (tx),
        .read_data_a   (read_data_a),
        .read_data_b   (read_data_b),
        .read_hit_a    (read_hit_a),
        .read_hit_b    (read_hit_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we_a;
        logic [15:0] addr_a;
        logic [15:0] wd_a;
        logic        we_b;
        logic [15:0] addr_b;
        logic [15:0] wd_b;
        logic        exp_tx;
        logic [15:0] exp_rd_a;
        logic        exp_hit_a;
        logic [15:0] exp_rd_b;
        logic        exp_hit_b;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic we_a, input logic [15:0] addr_a, input logic [15:0] wd_a,
                                input logic we_b, input logic [15:0] addr_b, input logic [15:0] wd_b,
                                input logic exp_tx, input logic [15:0] exp_rd_a, input logic exp_hit_a,
                                input logic [15:0] exp_rd_b, input logic exp_hit_b);
        vec_t v;
        v.we_a = we_a;  v.addr_a = addr_a;  v.wd_a = wd_a;
        v.we_b = we_b;  v.addr_b = addr_b;  v.wd_b = wd_b;
        v.exp_tx = exp_tx;
        v.exp_rd_a = exp_rd_a;  v.exp_hit_a = exp_hit_a;
        v.exp_rd_b = exp_rd_b;  v.exp_hit_b = exp_hit_b;
        return v;
    endfunction

    // Expected line level in cycle j (0..39) of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        int pos;
        pos = j / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we_a, input logic [15:0] addr_a, input logic [15:0] wd_a,
                         input logic we_b, input logic [15:0] addr_b, input logic [15:0] wd_b);
        write_enable_a = we_a;  address_a = addr_a;  write_data_a = wd_a;
        write_enable_b = we_b;  address_b = addr_b;  write_data_b = wd_b;
    endtask

    task automatic quiet();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, STATUS, 16'h0000);
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet();

        // Vectors start right after reset; port A pushes, port B mostly reads status.
        vecs[0]  = mk(1, DATA,   16'h0001, 0, STATUS, 16'h0000, 1, 16'h0000, 0, 16'h0001, 1);
        vecs[1]  = mk(1, DATA,   16'h0002, 0, STATUS, 16'h0000, 0, 16'h0000, 0, 16'h0001, 1);
        vecs[2]  = mk(1, DATA,   16'h0003, 0, STATUS, 16'h0000, 0, 16'h0000, 0, 16'h0001, 1);
        vecs[3]  = mk(1, DATA,   16'h0004, 0, STATUS, 16'h0000, 0, 16'h0000, 0, 16'h0001, 1);
        vecs[4]  = mk(1, DATA,   16'h0005, 0, STATUS, 16'h0000, 0, 16'h0000, 0, 16'h0003, 1);
        vecs[5]  = mk(1, DATA,   16'h0006, 0, STATUS, 16'h0000, 1, 16'h0000, 0, 16'h000B, 1);
        vecs[6]  = mk(0, STATUS, 16'h0000, 1, STATUS, 16'h0000, 1, 16'h0003, 1, 16'h0003, 1);
        vecs[7]  = mk(0, STATUS, 16'h0000, 0, OTHER,  16'h0000, 1, 16'h0003, 1, 16'h0000, 0);
        vecs[8]  = mk(1, OTHER,  16'h0055, 0, STATUS, 16'h0000, 1, 16'h0000, 0, 16'h0003, 1);
        vecs[9]  = mk(1, DATA,   16'h0066, 1, STATUS, 16'h0000, 0, 16'h0000, 0, 16'h000B, 1);
        vecs[10] = mk(0, STATUS, 16'h0000, 1, STATUS, 16'hFFFF, 0, 16'h0003, 1, 16'h0003, 1);
        vecs[11] = mk(1, DATA,   16'h0077, 1, DATA,   16'h0088, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[12] = mk(0, STATUS, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h000B, 1, 16'h0000, 0);

        step();
        step();
        reset = 1'b0;
        step();
        check("reset_tx", 16'(tx), 16'h0001);
        check("reset_status", read_data_b, 16'h0004);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we_a, vecs[i].addr_a, vecs[i].wd_a,
                  vecs[i].we_b, vecs[i].addr_b, vecs[i].wd_b);
            step();
            check($sformatf("vec%0d_tx", i), 16'(tx), 16'(vecs[i].exp_tx));
            check($sformatf("vec%0d_rd_a", i), read_data_a, vecs[i].exp_rd_a);
            check($sformatf("vec%0d_hit_a", i), 16'(read_hit_a), 16'(vecs[i].exp_hit_a));
            check($sformatf("vec%0d_rd_b", i), read_data_b, vecs[i].exp_rd_b);
            check($sformatf("vec%0d_hit_b", i), 16'(read_hit_b), 16'(vecs[i].exp_hit_b));
        end

        // Full FIFO accepts a push in the cycle the STOP bit ends and pops (edge 42).
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, STATUS, 16'h0000);
        step();
        quiet();
        for (int e = 15; e <= 41; e++) step();
        check("popfull_pre_tx", 16'(tx), 16'h0001);
        check("popfull_pre_status", read_data_b, 16'h0003);
        drive(1'b1, DATA, 16'h0099, 1'b0, STATUS, 16'h0000);
        step();
        check("popfull_tx", 16'(tx), 16'h0000);
        check("popfull_status", read_data_b, 16'h0003);
        drive(1'b1, DATA, 16'h00AA, 1'b0, STATUS, 16'h0000);
        step();
        check("popfull_next_drop", read_data_b, 16'h000B);

        // Single 0xA5 frame: exact line levels and idle afterwards.
        do_reset();
        drive(1'b1, DATA, 16'h00A5, 1'b0, STATUS, 16'h0000);
        step();
        quiet();
        for (int i = 1; i <= 40; i++) begin
            step();
            check($sformatf("frameA5_c%0d", i), 16'(tx), 16'(frame_bit(8'hA5, i - 1)));
            if (i == 1) check("frameA5_busy", read_data_b, 16'h0005);
        end
        step();
        check("frameA5_idle_status", read_data_b, 16'h0004);
        check("frameA5_idle_tx", 16'(tx), 16'h0001);

        // Simultaneous A/B pushes: 0x11 then 0x22 with no gap.
        do_reset();
        drive(1'b1, DATA, 16'h0011, 1'b1, DATA, 16'h0022);
        step();
        quiet();
        for (int i = 1; i <= 80; i++) begin
            step();
            check($sformatf("pair_c%0d", i), 16'(tx),
                  16'(frame_bit((i <= 40) ? 8'h11 : 8'h22, (i - 1) % 40)));
        end
        step();
        check("pair_idle_status", read_data_b, 16'h0004);

        // Reset mid-DATA with two bytes queued; a write during reset is discarded.
        do_reset();
        drive(1'b1, DATA, 16'h000F, 1'b1, DATA, 16'h00F0);
        step();
        drive(1'b1, DATA, 16'h0033, 1'b0, STATUS, 16'h0000);
        step();
        quiet();
        for (int i = 0; i < 9; i++) step();
        check("midreset_pre_status", read_data_b, 16'h0001);
        drive(1'b1, DATA, 16'h0077, 1'b0, STATUS, 16'h0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        quiet();
        check("midreset_tx", 16'(tx), 16'h0001);
        check("midreset_status", read_data_b, 16'h0004);
        for (int i = 0; i < 60; i++) begin
            step();
            check($sformatf("midreset_quiet_c%0d", i), 16'(tx), 16'h0001);
        end
        check("midreset_final_status", read_data_b, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
